// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode sequencer with a 4-entry return stack and fault halting
module fetch_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        instrValid,
  input  logic [15:0] pcIndex,
  input  logic        branchTaken,
  input  logic        execDone,
  output logic        pcEnable,
  output logic        pcIncOrSet,
  output logic [15:0] pcNewValue,
  output logic        memReq,
  output logic [15:0] irOut,
  output logic        irValid,
  output logic        halted,
  output logic [1:0]  faultCode
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, OPFETCH, BRANCH, EXEC, HALT} state_t;
  state_t state;
  logic [15:0] ir, tgt, ret_val;
  logic [15:0] stack [4];
  logic [2:0] sp;
  logic halt_pend, is_jmp, is_br, is_call, is_ret, is_hlt, taken, tgt_bad, call_full, push;
  assign is_jmp = ir[15:12] == 4'hC;
  assign is_br = ir[15:12] == 4'hD;
  assign is_call = ir[15:12] == 4'hE;
  assign is_ret = ir == 16'hF000;
  assign is_hlt = ir == 16'hFFFF;
  assign taken = is_jmp || is_call || (is_br && branchTaken);
  assign tgt_bad = tgt > 16'hBFFF;
  assign call_full = is_call && sp == 3'd4;
  assign push = state == BRANCH && is_call && !call_full && !tgt_bad;
  assign ret_val = stack[sp[1:0] - 2'd1];
  // Stack storage carries no reset: entries are only ever read below sp.
  always_ff @(posedge clock)
    if (push) stack[sp[1:0]] <= pcIndex + 16'd1;
  // memReq is raised one cycle after entering FETCH/OPFETCH so any pending PC strobe has landed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ir <= '0;
      tgt <= '0;
      sp <= '0;
      halt_pend <= 1'b0;
      pcEnable <= 1'b0;
      pcIncOrSet <= 1'b0;
      pcNewValue <= '0;
      memReq <= 1'b0;
      irOut <= '0;
      irValid <= 1'b0;
      halted <= 1'b0;
      faultCode <= '0;
    end else begin
      pcEnable <= 1'b0;
      pcIncOrSet <= 1'b0;
      pcNewValue <= '0;
      case (state)
        IDLE: state <= run ? FETCH : IDLE;
        FETCH, OPFETCH:
          if (memReq && instrValid) begin
            if (state == FETCH) ir <= instr;
            else tgt <= instr;
            memReq <= 1'b0;
            state <= state == FETCH ? DECODE : BRANCH;
          end else memReq <= 1'b1;
        DECODE:
          if (is_hlt || (is_ret && (sp == 3'd0 || ret_val > 16'hBFFF))) begin
            state <= HALT;
            halted <= 1'b1;
            faultCode <= is_hlt ? 2'd0 : sp == 3'd0 ? 2'd2 : 2'd3;
          end else if (is_ret) begin
            sp <= sp - 3'd1;
            pcEnable <= 1'b1;
            pcIncOrSet <= 1'b1;
            pcNewValue <= ret_val;
            state <= FETCH;
          end else if (is_jmp || is_br || is_call) begin
            pcEnable <= 1'b1;
            state <= OPFETCH;
          end else begin
            halt_pend <= pcIndex == 16'hBFFF;
            pcEnable <= pcIndex != 16'hBFFF;
            irOut <= ir;
            irValid <= 1'b1;
            state <= EXEC;
          end
        BRANCH:
          if (call_full || (taken && tgt_bad)) begin
            state <= HALT;
            halted <= 1'b1;
            faultCode <= call_full ? 2'd1 : 2'd3;
          end else begin
            pcEnable <= 1'b1;
            pcIncOrSet <= taken;
            pcNewValue <= taken ? tgt : '0;
            sp <= sp + {2'b0, is_call};
            state <= FETCH;
          end
        EXEC:
          if (execDone) begin
            irOut <= '0;
            irValid <= 1'b0;
            halted <= halt_pend;
            state <= halt_pend ? HALT : FETCH;
          end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench against an instruction-level program model
module tb_fetch_sequencer;
  logic clock = 1'b0, reset = 1'b0, run = 1'b0, instrValid = 1'b0, branchTaken = 1'b0, execDone = 1'b0;
  logic [15:0] instr = '0, pc_reg = '0, pcIndex;
  logic pcEnable, pcIncOrSet, memReq, irValid, halted;
  logic [15:0] pcNewValue, irOut;
  logic [1:0] faultCode;
  assign pcIndex = pc_reg;
  fetch_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .instrValid(instrValid),
    .pcIndex(pcIndex), .branchTaken(branchTaken), .execDone(execDone),
    .pcEnable(pcEnable), .pcIncOrSet(pcIncOrSet), .pcNewValue(pcNewValue), .memReq(memReq),
    .irOut(irOut), .irValid(irValid), .halted(halted), .faultCode(faultCode)
  );
  always #5 clock = ~clock;
  localparam logic [1:0] INC = 2'd0, LOAD = 2'd1, ISSUE = 2'd2, HLT = 2'd3;
  logic [15:0] mem [65536];
  bit taken_tbl [65536];
  logic [17:0] exp_q [$];
  int len_q [$];
  int vectors = 0, miscompares = 0, fixed_dly = 0, dly = 0, cnt = 0, irv_len = 0;
  bit allow_extra = 0, prv_env = 0, prev_en = 0, prev_irv = 0, prev_halt = 0;

  function automatic logic [39:0] outs();
    return {1'b0, pcEnable, pcIncOrSet, pcNewValue, memReq, irOut, irValid, halted, faultCode};
  endfunction

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_event(input logic [17:0] got);
    if (exp_q.size() == 0) begin
      if (!allow_extra) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got %h want none at %0t", got, $time);
      end
    end else check("event", {22'b0, got}, {22'b0, exp_q.pop_front()});
  endtask

  // Environment: program counter register, memory, branch flag and datapath completion.
  always @(negedge clock) begin
    if (!reset) begin
      instrValid = 1'b0;
      execDone = 1'b0;
      cnt = 0;
      prv_env = 1'b0;
    end else begin
      if (pcEnable) pc_reg = pcIncOrSet ? pcNewValue : pc_reg + 16'd1;
      branchTaken = taken_tbl[pc_reg];
      instrValid = memReq && $urandom_range(0, 2) != 0;
      instr = instrValid ? mem[pc_reg] : 16'($urandom);
      if (irValid && !prv_env) begin
        dly = fixed_dly != 0 ? fixed_dly : int'($urandom_range(1, 4));
        len_q.push_back(dly);
        cnt = 0;
      end
      cnt = irValid ? cnt + 1 : 0;
      execDone = irValid && cnt == dly;
      prv_env = irValid;
    end
  end

  // Monitor: compares every observable DUT event against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      prev_en = 0;
      prev_irv = 0;
      prev_halt = 0;
      irv_len = 0;
    end else begin
      if (pcEnable) begin
        check("pc_strobe_back_to_back", {39'b0, prev_en}, 40'd0);
        if (!pcIncOrSet) check("newvalue_on_increment", {24'b0, pcNewValue}, 40'd0);
        check_event({pcIncOrSet ? LOAD : INC, pcIncOrSet ? pcNewValue : 16'h0});
      end
      if (irValid && !prev_irv) check_event({ISSUE, irOut});
      irv_len = irValid ? irv_len + 1 : irv_len;
      if (!irValid && prev_irv) begin
        check("irvalid_cycles", 40'(irv_len), len_q.size() != 0 ? 40'(len_q.pop_front()) : '1);
        irv_len = 0;
      end
      if (halted && !prev_halt) check_event({HLT, 14'b0, faultCode});
      if (halted && prev_halt) check("halt_quiet", {21'b0, pcEnable, memReq, irValid, irOut}, 40'd0);
      prev_en = pcEnable;
      prev_irv = irValid;
      prev_halt = halted;
    end
  end

  // Reference: executes the program one instruction at a time and lists the visible events.
  task automatic model(input logic [15:0] s, input int lim, output bit trunc);
    logic [15:0] pc, w, t, a;
    logic [15:0] stk [$];
    bit take;
    pc = s;
    trunc = 0;
    for (int n = 0; n < lim; n++) begin
      w = mem[pc];
      a = pc + 16'd1;
      if (w == 16'hFFFF) begin
        exp_q.push_back({HLT, 16'd0});
        return;
      end
      if (w == 16'hF000) begin
        if (stk.size() == 0) begin
          exp_q.push_back({HLT, 16'd2});
          return;
        end
        t = stk.pop_back();
        if (t > 16'hBFFF) begin
          exp_q.push_back({HLT, 16'd3});
          return;
        end
        exp_q.push_back({LOAD, t});
        pc = t;
      end else if (w[15:12] >= 4'hC && w[15:12] <= 4'hE) begin
        exp_q.push_back({INC, 16'h0});
        t = mem[a];
        take = w[15:12] != 4'hD || taken_tbl[a];
        if (w[15:12] == 4'hE && stk.size() == 4) begin
          exp_q.push_back({HLT, 16'd1});
          return;
        end
        if (take && t > 16'hBFFF) begin
          exp_q.push_back({HLT, 16'd3});
          return;
        end
        if (w[15:12] == 4'hE) stk.push_back(pc + 16'd2);
        exp_q.push_back(take ? {LOAD, t} : {INC, 16'h0});
        pc = take ? t : pc + 16'd2;
      end else begin
        if (pc == 16'hBFFF) begin
          exp_q.push_back({ISSUE, w});
          exp_q.push_back({HLT, 16'd0});
          return;
        end
        exp_q.push_back({INC, 16'h0});
        exp_q.push_back({ISSUE, w});
        pc = a;
      end
    end
    trunc = 1;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
    foreach (taken_tbl[i]) taken_tbl[i] = 0;
  endtask

  task automatic do_reset(input logic [15:0] s);
    @(posedge clock);
    #2 reset = 1'b0;
    exp_q.delete();
    len_q.delete();
    allow_extra = 0;
    pc_reg = s;
    repeat (2) @(posedge clock);
    #1 check("reset_outputs", outs(), 40'd0);
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic launch(input logic [15:0] s, output bit trunc);
    model(s, 60, trunc);
    @(posedge clock);
    #2 run = 1'b1;
    @(posedge clock);
    #2 run = 1'b0;
  endtask

  task automatic drain(input bit trunc);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clock);
    check("events_drained", 40'(exp_q.size()), 40'd0);
    if (trunc) allow_extra = 1;
    else repeat (8) @(negedge clock);
  endtask

  task automatic run_prog(input logic [15:0] s);
    bit trunc;
    do_reset(s);
    launch(s, trunc);
    drain(trunc);
  endtask

  initial begin
    bit seen, act, trunc;
    logic [15:0] w;
    int r;
    clear_mem();
    mem[0] = 16'h1234;
    mem[1] = 16'hFFFF;
    fixed_dly = 3;
    run_prog(16'h0000);
    fixed_dly = 0;
    clear_mem();
    mem[0] = 16'hC000;
    mem[1] = 16'h0100;
    mem[16'h100] = 16'hD000;
    mem[16'h101] = 16'h0050;
    mem[16'h102] = 16'hFFFF;
    run_prog(16'h0000);
    clear_mem();
    mem[16'h10] = 16'hE000;
    mem[16'h11] = 16'h0200;
    mem[16'h200] = 16'hF000;
    mem[16'h12] = 16'hFFFF;
    run_prog(16'h0010);
    clear_mem();
    for (int k = 0; k < 5; k++) begin
      mem[16 * k] = 16'hE000;
      mem[16 * k + 1] = 16'(16 * (k + 1));
    end
    run_prog(16'h0000);
    clear_mem();
    mem[0] = 16'hF000;
    run_prog(16'h0000);
    clear_mem();
    mem[0] = 16'hC000;
    mem[1] = 16'hC000;
    run_prog(16'h0000);
    clear_mem();
    mem[16'hBFFF] = 16'h1234;
    run_prog(16'hBFFF);
    clear_mem();
    mem[0] = 16'hC000;
    mem[1] = 16'h0100;
    mem[16'h100] = 16'hFFFF;
    do_reset(16'h0000);
    launch(16'h0000, trunc);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) @(negedge clock) seen = pcEnable;
    check("reached_opfetch", {39'b0, seen}, 40'd1);
    @(posedge clock);
    #2 reset = 1'b0;
    exp_q.delete();
    len_q.delete();
    #1 check("async_reset_outputs", outs(), 40'd0);
    pc_reg = '0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    act = 0;
    repeat (6) @(negedge clock) act |= memReq | pcEnable | halted;
    check("idle_without_run", {39'b0, act}, 40'd0);
    launch(16'h0000, trunc);
    drain(trunc);
    repeat (40) begin
      clear_mem();
      for (int a = 0; a < 128; a++) begin
        r = $urandom_range(0, 99);
        w = r < 25 ? 16'($urandom_range(0, 127)) :
            r < 50 ? {4'($urandom_range(0, 11)), 12'($urandom)} :
            r < 60 ? {4'hC, 12'($urandom)} :
            r < 70 ? {4'hD, 12'($urandom)} :
            r < 80 ? {4'hE, 12'($urandom)} :
            r < 88 ? 16'hF000 :
            r < 93 ? 16'hFFFF : 16'($urandom);
        mem[a] = w;
      end
      for (int a = 0; a < 256; a++) taken_tbl[a] = 1'($urandom);
      run_prog(16'h0000);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port run  input  1  start request, sampled in IDLE only.
REQ-004 SHALL have port instr  input  16  memory read data at current PC.
REQ-005 SHALL have port instrValid  input  1  memory handshake; instr valid this cycle.
REQ-006 SHALL have port pcIndex  input  16  current program counter value (readback).
REQ-007 SHALL have port branchTaken  input  1  condition flag for BR, sampled in BRANCH.
REQ-008 SHALL have port execDone  input  1  datapath completion for an ordinary instruction.
REQ-009 SHALL have port pcEnable  output  1  program counter update strobe.
REQ-010 SHALL have port pcIncOrSet  output  1  0 = increment, 1 = load pcNewValue.
REQ-011 SHALL have port pcNewValue  output  16  program counter load value.
REQ-012 SHALL have port memReq  output  1  fetch request at address pcIndex.
REQ-013 SHALL have ports irOut, irValid, halted and faultCode  output  16/1/1/2  issued instruction, issue-valid flag, halted flag and fault code.

Function
REQ-014 SHALL implement the states IDLE, FETCH, DECODE, OPFETCH, BRANCH, EXEC and HALT.
REQ-015 IDLE SHALL move to FETCH on run=1, otherwise remain in IDLE.
REQ-016 FETCH SHALL assert memReq; on instrValid=1 SHALL latch instr into IR and move to DECODE; otherwise SHALL hold with no timeout.
REQ-017 DECODE SHALL classify IR[15:12]: C=JMP, D=BR, E=CALL; F with IR[11:0]=000 = RET; F with IR[11:0]=FFF = HALT; all other encodings = ordinary.
REQ-018 For an ordinary instruction at pcIndex<0xBFFF, DECODE SHALL pulse pcEnable=1 with pcIncOrSet=0 for one cycle and move to EXEC.
REQ-019 For an ordinary instruction at pcIndex=0xBFFF, DECODE SHALL NOT pulse pcEnable; after EXEC completes, the next state SHALL be HALT with faultCode=0.
REQ-020 EXEC SHALL drive irOut=IR with irValid=1 until execDone=1, then move to FETCH (or HALT per REQ-019); irValid SHALL be 0 in all other states.
REQ-021 For JMP, BR and CALL, DECODE SHALL pulse a PC increment and move to OPFETCH.
REQ-022 OPFETCH SHALL assert memReq and, on instrValid, latch the target word and move to BRANCH.
REQ-023 In BRANCH, a transfer SHALL be taken for JMP, for CALL, and for BR when branchTaken=1.
REQ-024 A taken transfer SHALL pulse pcEnable=1, pcIncOrSet=1, pcNewValue=target.
REQ-025 A BR that is not taken SHALL pulse an increment to skip the operand word.
REQ-026 After BRANCH, the next state SHALL be FETCH.
REQ-027 CALL SHALL push pcIndex+1, computed mod 2^16 in BRANCH, onto a 4-entry, 16-bit return stack before the jump.
REQ-028 RET in DECODE SHALL pop the top entry and pulse a load of that value, then move to FETCH.
REQ-029 A target greater than 0xBFFF SHALL NOT load the PC; the block SHALL enter HALT with faultCode=3.
REQ-030 A CALL with the stack full (4 entries) SHALL enter HALT with faultCode=1, with no push and no PC update.
REQ-031 A RET with the stack empty SHALL enter HALT with faultCode=2, with no PC update.
REQ-032 The HALT opcode SHALL enter HALT with faultCode=0 and no PC update.
REQ-033 HALT SHALL set halted=1 and hold all other outputs inactive until reset; run SHALL be ignored in HALT.
REQ-034 pcEnable SHALL be high for exactly one cycle per PC update and never in two consecutive cycles.
REQ-035 pcNewValue SHALL be 0 whenever pcIncOrSet=0.

Reset
REQ-036 reset=0 SHALL immediately force state IDLE, the stack pointer to 0 and IR to 0.
REQ-037 reset=0 SHALL immediately force pcEnable, pcIncOrSet, pcNewValue, memReq, irOut, irValid, halted and faultCode to 0.
REQ-038 Reset asserted mid-operation (any state) SHALL abandon the current instruction; no PC strobe SHALL occur in the cycle reset deasserts.
REQ-039 Stack contents SHALL be treated as invalid after reset.

Verification
REQ-040 Bench SHALL cover: run=1, PC=0, ordinary instr 0x1234, execDone after 3 cycles -> one increment strobe, irOut=0x1234, irValid high 3 cycles, back to FETCH.
REQ-041 Bench SHALL cover: JMP 0xC000 followed by operand 0x0100 -> two strobes, increment then load 0x0100; BR with branchTaken=0 -> two increments.
REQ-042 Bench SHALL cover: CALL at 0x0010 to 0x0200, then RET -> stack receives 0x0012; RET loads 0x0012.
REQ-043 Bench SHALL cover: five nested CALLs -> fifth gives halted=1 and faultCode=1; RET on an empty stack -> faultCode=2; JMP to 0xC000 -> faultCode=3 with no load.
REQ-044 Bench SHALL cover: ordinary instr at 0xBFFF -> no increment strobe, HALT with faultCode=0 after execDone.
REQ-045 Bench SHALL cover: reset pulsed during OPFETCH -> all outputs 0 asynchronously, IDLE, and run is required again to resume.
